// File: rtl/memwb_writeback.sv
// MEM/WB pipeline register and write-back selector feeding the register file write port.
// Aligns and extends big-endian load data, masks R0 writes, and keeps retire and misalign status.
module memwb_writeback #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_RegWr,
  input  logic [4:0]       in_Rw,
  input  logic [1:0]       in_sel,
  input  logic [1:0]       in_ld_size,
  input  logic             in_ld_unsigned,
  input  logic [WIDTH-1:0] in_alu,
  input  logic [WIDTH-1:0] in_mem_rdata,
  input  logic [WIDTH-1:0] in_pc8,
  input  logic             freeze,
  input  logic             flush,
  output logic             RegWr,
  output logic [4:0]       Rw,
  output logic [WIDTH-1:0] busW,
  output logic             fwd_valid,
  output logic [4:0]       fwd_Rw,
  output logic [WIDTH-1:0] fwd_data,
  output logic [CNT_W-1:0] instret,
  output logic             ld_misalign
);

  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  logic             wb_valid;
  logic             wb_RegWr;
  logic [4:0]       wb_Rw;
  logic [1:0]       wb_sel;
  logic [1:0]       wb_ld_size;
  logic             wb_ld_unsigned;
  logic [WIDTH-1:0] wb_alu;
  logic [WIDTH-1:0] wb_mem_rdata;
  logic [WIDTH-1:0] wb_pc8;

  logic [BYTE_W-1:0] byte_val;
  logic [HALF_W-1:0] half_val;
  logic [WIDTH-1:0]  ld_val;
  logic              misaligned;
  logic              misalign_now;
  logic              regwr_c;
  logic [4:0]        rw_c;
  logic [WIDTH-1:0]  busw_c;

  // WB register: freeze holds, flush injects a bubble, otherwise capture MEM stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid       <= 1'b0;
      wb_RegWr       <= 1'b0;
      wb_Rw          <= 5'd0;
      wb_sel         <= 2'd0;
      wb_ld_size     <= 2'd0;
      wb_ld_unsigned <= 1'b0;
      wb_alu         <= '0;
      wb_mem_rdata   <= '0;
      wb_pc8         <= '0;
    end else if (!freeze) begin
      if (flush) begin
        wb_valid <= 1'b0;
      end else begin
        wb_valid       <= in_valid;
        wb_RegWr       <= in_RegWr;
        wb_Rw          <= in_Rw;
        wb_sel         <= in_sel;
        wb_ld_size     <= in_ld_size;
        wb_ld_unsigned <= in_ld_unsigned;
        wb_alu         <= in_alu;
        wb_mem_rdata   <= in_mem_rdata;
        wb_pc8         <= in_pc8;
      end
    end
  end

  // Big-endian lane select: address 0 is the most significant byte
  always_comb begin
    byte_val   = '0;
    half_val   = '0;
    ld_val     = '0;
    misaligned = 1'b0;

    case (wb_alu[1:0])
      2'd0:    byte_val = wb_mem_rdata[31:24];
      2'd1:    byte_val = wb_mem_rdata[23:16];
      2'd2:    byte_val = wb_mem_rdata[15:8];
      default: byte_val = wb_mem_rdata[7:0];
    endcase

    half_val = wb_alu[1] ? wb_mem_rdata[15:0] : wb_mem_rdata[31:16];

    case (wb_ld_size)
      SZ_HALF: begin
        misaligned = wb_alu[0];
        ld_val = wb_ld_unsigned ? {{(WIDTH-HALF_W){1'b0}}, half_val}
                                : {{(WIDTH-HALF_W){half_val[HALF_W-1]}}, half_val};
      end
      SZ_BYTE: begin
        ld_val = wb_ld_unsigned ? {{(WIDTH-BYTE_W){1'b0}}, byte_val}
                                : {{(WIDTH-BYTE_W){byte_val[BYTE_W-1]}}, byte_val};
      end
      default: begin
        misaligned = |wb_alu[1:0];
        ld_val     = wb_mem_rdata;
      end
    endcase
  end

  // Write-back mux and write qualification; bubbles present all zeros
  always_comb begin
    busw_c       = '0;
    rw_c         = 5'd0;
    misalign_now = wb_valid & (wb_sel == SEL_LOAD) & misaligned;
    regwr_c      = wb_valid & wb_RegWr & (wb_Rw != 5'd0) & ~freeze & ~misalign_now;

    if (wb_valid) begin
      rw_c = wb_Rw;
      case (wb_sel)
        SEL_LOAD: busw_c = ld_val;
        SEL_LINK: busw_c = wb_pc8;
        SEL_ALU:  busw_c = wb_alu;
        default:  busw_c = wb_alu;
      endcase
    end
  end

  assign RegWr     = regwr_c;
  assign Rw        = rw_c;
  assign busW      = busw_c;
  assign fwd_valid = regwr_c;
  assign fwd_Rw    = rw_c;
  assign fwd_data  = busw_c;

  // Retire counter and sticky misaligned-load flag advance only when WB is not frozen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret     <= '0;
      ld_misalign <= 1'b0;
    end else if (!freeze) begin
      if (wb_valid) begin
        instret <= instret + CNT_W'(1);
      end
      if (misalign_now) begin
        ld_misalign <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memwb_writeback.sv
// Directed bench for memwb_writeback with a small register file model on its write port.
module tb_memwb_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_RegWr;
  logic [4:0]  in_Rw;
  logic [1:0]  in_sel;
  logic [1:0]  in_ld_size;
  logic        in_ld_unsigned;
  logic [31:0] in_alu;
  logic [31:0] in_mem_rdata;
  logic [31:0] in_pc8;
  logic        freeze;
  logic        flush;
  logic        RegWr;
  logic [4:0]  Rw;
  logic [31:0] busW;
  logic        fwd_valid;
  logic [4:0]  fwd_Rw;
  logic [31:0] fwd_data;
  logic [3:0]  instret;
  logic        ld_misalign;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [32] = '{default: 32'h0};
  int          r31_writes = 0;
  int          wr_count   = 0;
  int          wr_before;

  memwb_writeback #(.WIDTH(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_RegWr(in_RegWr),
    .in_Rw(in_Rw), .in_sel(in_sel), .in_ld_size(in_ld_size),
    .in_ld_unsigned(in_ld_unsigned), .in_alu(in_alu), .in_mem_rdata(in_mem_rdata),
    .in_pc8(in_pc8), .freeze(freeze), .flush(flush), .RegWr(RegWr), .Rw(Rw),
    .busW(busW), .fwd_valid(fwd_valid), .fwd_Rw(fwd_Rw), .fwd_data(fwd_data),
    .instret(instret), .ld_misalign(ld_misalign)
  );

  always #5 clk = ~clk;

  // Downstream register file
  always @(posedge clk) begin
    if (RegWr) begin
      rf[Rw]   <= busW;
      wr_count <= wr_count + 1;
      if (Rw == 5'd31) r31_writes <= r31_writes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge, then fall back to a bubble
  task automatic issue(input logic [4:0] rw, input logic [1:0] sel, input logic [1:0] size,
                       input logic uns, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc8);
    in_valid       = 1'b1;
    in_RegWr       = 1'b1;
    in_Rw          = rw;
    in_sel         = sel;
    in_ld_size     = size;
    in_ld_unsigned = uns;
    in_alu         = alu;
    in_mem_rdata   = rdata;
    in_pc8         = pc8;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_fwd(input string tag);
    check({tag, "_fwd_valid"}, 32'(fwd_valid), 32'(RegWr));
    check({tag, "_fwd_rw"}, 32'(fwd_Rw), 32'(Rw));
    check({tag, "_fwd_data"}, fwd_data, busW);
  endtask

  localparam logic [31:0] RD = 32'h80F1_7F02;

  initial begin
    rst_n = 1'b0; freeze = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_RegWr = 1'b1; in_Rw = 5'd3; in_sel = 2'b00;
    in_ld_size = 2'b00; in_ld_unsigned = 1'b0; in_alu = 32'hDEAD_BEEF;
    in_mem_rdata = 32'h0; in_pc8 = 32'h0;

    // Reset with a valid instruction on the inputs
    tick(); tick();
    check("rst_regwr", 32'(RegWr), 32'h0);
    check("rst_rw", 32'(Rw), 32'h0);
    check("rst_busw", busW, 32'h0);
    check("rst_instret", 32'(instret), 32'h0);
    check("rst_misalign", 32'(ld_misalign), 32'h0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();

    // ALU write to R5, then to R0
    issue(5'd5, 2'b00, 2'b00, 1'b0, 32'h1234_5678, 32'h0, 32'h0);
    check("alu_regwr", 32'(RegWr), 32'h1);
    check("alu_rw", 32'(Rw), 32'd5);
    check("alu_busw", busW, 32'h1234_5678);
    check_fwd("alu");
    check("alu_instret0", 32'(instret), 32'h0);
    issue(5'd0, 2'b00, 2'b00, 1'b0, 32'h0000_AAAA, 32'h0, 32'h0);
    check("rf_r5", rf[5], 32'h1234_5678);
    check("instret1", 32'(instret), 32'd1);
    check("r0_regwr", 32'(RegWr), 32'h0);
    check("r0_busw", busW, 32'h0000_AAAA);

    // Load alignment and extension
    issue(5'd1, 2'b01, 2'b10, 1'b0, 32'h0000_1000, RD, 32'h0);
    check("r0_instret", 32'(instret), 32'd2);
    check("lb_a0_s", busW, 32'hFFFF_FF80);
    check("lb_regwr", 32'(RegWr), 32'h1);
    issue(5'd2, 2'b01, 2'b10, 1'b1, 32'h0000_1000, RD, 32'h0);
    check("lb_a0_u", busW, 32'h0000_0080);
    issue(5'd3, 2'b01, 2'b01, 1'b0, 32'h0000_1002, RD, 32'h0);
    check("lh_a2_s", busW, 32'h0000_7F02);
    issue(5'd4, 2'b01, 2'b10, 1'b0, 32'h0000_1003, RD, 32'h0);
    check("lb_a3", busW, 32'h0000_0002);
    issue(5'd6, 2'b01, 2'b10, 1'b0, 32'h0000_1001, RD, 32'h0);
    check("lb_a1_s", busW, 32'hFFFF_FFF1);
    issue(5'd11, 2'b01, 2'b01, 1'b1, 32'h0000_1000, RD, 32'h0);
    check("lh_a0_u", busW, 32'h0000_80F1);
    check_fwd("lh");

    // Misaligned half load, then a normal ALU write
    issue(5'd7, 2'b01, 2'b01, 1'b0, 32'h0000_1001, RD, 32'h0);
    check("mis_regwr", 32'(RegWr), 32'h0);
    check("mis_flag_pre", 32'(ld_misalign), 32'h0);
    check("mis_instret", 32'(instret), 32'd8);
    issue(5'd8, 2'b00, 2'b00, 1'b0, 32'h0000_0055, 32'h0, 32'h0);
    check("mis_flag", 32'(ld_misalign), 32'h1);
    check("post_mis_regwr", 32'(RegWr), 32'h1);
    tick();
    check("rf_r7", rf[7], 32'h0);
    check("rf_r8", rf[8], 32'h0000_0055);
    check("mis_sticky", 32'(ld_misalign), 32'h1);
    check("instret10", 32'(instret), 32'd10);

    // Link write held by a 3-cycle freeze; last frozen cycle also flushes
    issue(5'd31, 2'b10, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0040_0010);
    freeze = 1'b1;
    in_valid = 1'b1; in_Rw = 5'd12; in_sel = 2'b00; in_alu = 32'h0BAD_0BAD;
    #1;
    check("frz_regwr0", 32'(RegWr), 32'h0);
    tick();
    check("frz_regwr1", 32'(RegWr), 32'h0);
    tick();
    flush = 1'b1;
    #1;
    check("frz_regwr2", 32'(RegWr), 32'h0);
    tick();
    flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
    #1;
    check("frz_instret", 32'(instret), 32'd10);
    check("unfrz_regwr", 32'(RegWr), 32'h1);
    check("unfrz_rw", 32'(Rw), 32'd31);
    check("unfrz_busw", busW, 32'h0040_0010);
    tick();
    check("rf_r31", rf[31], 32'h0040_0010);
    check("unfrz_instret", 32'(instret), 32'd11);
    tick();
    check("r31_once", 32'(r31_writes), 32'd1);
    check("rf_r12", rf[12], 32'h0);

    // Flush replaces a valid instruction with a bubble
    flush = 1'b1;
    issue(5'd9, 2'b00, 2'b00, 1'b0, 32'h0000_0099, 32'h0, 32'h0);
    flush = 1'b0;
    check("flush_regwr", 32'(RegWr), 32'h0);
    check("flush_busw", busW, 32'h0);
    check("flush_rw", 32'(Rw), 32'h0);
    tick();
    check("flush_instret", 32'(instret), 32'd11);
    check("rf_r9", rf[9], 32'h0);

    // Counter wrap at 4 bits: 17 retirements from reset read back as 1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_RegWr = 1'b1; in_Rw = 5'd13; in_sel = 2'b00; in_alu = 32'h1;
    for (int i = 0; i < 17; i++) tick();
    in_valid = 1'b0;
    tick();
    check("wrap_instret", 32'(instret), 32'd1);
    check("wrap_misalign", 32'(ld_misalign), 32'h0);

    // Reset while frozen discards the held instruction
    issue(5'd10, 2'b00, 2'b00, 1'b0, 32'h0000_0077, 32'h0, 32'h0);
    wr_before = wr_count;
    freeze = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; freeze = 1'b0;
    #1;
    check("rstfrz_regwr", 32'(RegWr), 32'h0);
    check("rstfrz_busw", busW, 32'h0);
    tick(); tick();
    check("rstfrz_writes", 32'(wr_count - wr_before), 32'h0);
    check("rf_r10", rf[10], 32'h0);
    check("rstfrz_instret", 32'(instret), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
